sprite_line_writer: RTL and testbench



---
 rtl/sprite_line_writer.sv | 225 ++++++++++++++++++++++
 tb/tb_sprite_line_writer.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_line_writer.sv
// Writer side of the ping-pong scanline buffer: clears the back half on each
// line start, then draws up to NUM_SPRITES 2x-scaled 8x8 sprites into it.

module sprite_attr_slot (
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_We,
    input  logic [1:0] i_Field,
    input  logic [9:0] i_Data,
    output logic [9:0] o_X,
    output logic [9:0] o_Y,
    output logic [5:0] o_Num,
    output logic       o_En
);
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [5:0] r_num;
    logic       r_en;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_x   <= '0;
            r_y   <= '0;
            r_num <= '0;
            r_en  <= 1'b0;
        end else if (i_We) begin
            case (i_Field)
                2'd0: r_x <= i_Data;
                2'd1: r_y <= i_Data;
                2'd2: begin
                    r_num <= i_Data[5:0];
                    r_en  <= i_Data[8];
                end
                default: ;
            endcase
        end
    end

    assign o_X   = r_x;
    assign o_Y   = r_y;
    assign o_Num = r_num;
    assign o_En  = r_en;
endmodule

module sprite_line_writer #(
    parameter int         NUM_SPRITES = 8,
    parameter logic [3:0] ATTR_PAGE   = 4'hE
) (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Line_Start,
    input  logic [9:0]  i_Next_Row,
    input  logic        i_Bank,
    input  logic        i_Cpu_Write,
    input  logic [15:0] i_Cpu_Addr,
    input  logic [15:0] i_Cpu_Data,
    output logic [5:0]  o_Rom_Sprite,
    output logic [2:0]  o_Rom_Row,
    output logic [2:0]  o_Rom_Col,
    input  logic [1:0]  i_Rom_Pixel,
    output logic        o_Lr_Write,
    output logic [10:0] o_Lr_Addr,
    output logic [1:0]  o_Lr_Data,
    output logic        o_Busy,
    output logic        o_Overrun
);
    localparam int SW = $clog2(NUM_SPRITES);

    typedef enum logic [2:0] {IDLE, CLEAR, CHECK, DRAW, TAIL} state_t;
    state_t r_state, w_next;

    logic [NUM_SPRITES-1:0][9:0] w_x;
    logic [NUM_SPRITES-1:0][9:0] w_y;
    logic [NUM_SPRITES-1:0][5:0] w_num;
    logic [NUM_SPRITES-1:0]      w_en;

    logic          w_attr_wr;
    logic [SW-1:0] w_slot;

    assign w_attr_wr = i_Cpu_Write && (i_Cpu_Addr[15:12] == ATTR_PAGE);
    assign w_slot    = i_Cpu_Addr[2 +: SW];

    generate
        for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
            sprite_attr_slot u_slot (
                .i_Clk     (i_Clk),
                .i_Reset_n (i_Reset_n),
                .i_We      (w_attr_wr && (w_slot == SW'(g))),
                .i_Field   (i_Cpu_Addr[1:0]),
                .i_Data    (i_Cpu_Data[9:0]),
                .o_X       (w_x[g]),
                .o_Y       (w_y[g]),
                .o_Num     (w_num[g]),
                .o_En      (w_en[g])
            );
        end
    endgenerate

    logic [9:0]    r_row;
    logic          r_bank;
    logic [SW-1:0] r_s;
    logic [7:0]    r_cnt;
    logic [2:0]    r_dy_row;
    logic [5:0]    r_num;
    logic [7:0]    r_xb;
    logic          r_wr_vld;
    logic [8:0]    r_wr_addr;
    logic          r_overrun;

    logic [9:0] w_dy;
    logic       w_hit;
    logic       w_last;
    logic       w_pix_we;

    assign w_dy     = r_row - w_y[r_s];
    assign w_hit    = w_en[r_s] && (w_dy[9:4] == 6'd0);
    assign w_last   = (r_s == '0);
    // Bit 8 of the pending address means the pixel fell off the right edge.
    assign w_pix_we = r_wr_vld && !r_wr_addr[8] && (i_Rom_Pixel != 2'd0);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        o_Busy       = 1'b0;
        o_Lr_Write   = 1'b0;
        o_Lr_Addr    = '0;
        o_Lr_Data    = '0;
        o_Rom_Sprite = '0;
        o_Rom_Row    = '0;
        o_Rom_Col    = '0;
        case (r_state)
            IDLE: ;
            CLEAR: begin
                o_Busy     = 1'b1;
                o_Lr_Write = 1'b1;
                o_Lr_Addr  = {2'b00, r_bank, r_cnt};
                if (r_cnt == 8'hFF) w_next = CHECK;
            end
            CHECK: begin
                o_Busy = 1'b1;
                if (w_hit)       w_next = DRAW;
                else if (w_last) w_next = IDLE;
            end
            DRAW: begin
                o_Busy       = 1'b1;
                o_Rom_Sprite = r_num;
                o_Rom_Row    = r_dy_row;
                o_Rom_Col    = r_cnt[2:0];
                if (r_cnt[2:0] == 3'd7) w_next = TAIL;
            end
            TAIL: begin
                o_Busy = 1'b1;
                w_next = w_last ? IDLE : CHECK;
            end
            default: w_next = IDLE;
        endcase
        if (w_pix_we) begin
            o_Lr_Write = 1'b1;
            o_Lr_Addr  = {2'b00, r_bank, r_wr_addr[7:0]};
            o_Lr_Data  = i_Rom_Pixel;
        end
        if (i_Line_Start) w_next = CLEAR;
    end

    // Attributes of the sprite being drawn are latched at CHECK so CPU
    // writes landing mid-draw only affect sprites not yet examined.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_row     <= '0;
            r_bank    <= 1'b0;
            r_s       <= '0;
            r_cnt     <= '0;
            r_dy_row  <= '0;
            r_num     <= '0;
            r_xb      <= '0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_wr_vld  <= (r_state == DRAW) && !i_Line_Start;
            r_wr_addr <= {1'b0, r_xb} + {6'd0, r_cnt[2:0]};
            if (i_Line_Start) begin
                r_row  <= i_Next_Row;
                r_bank <= i_Bank;
                r_s    <= SW'(NUM_SPRITES - 1);
                r_cnt  <= '0;
            end else begin
                case (r_state)
                    CLEAR: r_cnt <= r_cnt + 8'd1;
                    CHECK: begin
                        if (w_hit) begin
                            r_dy_row <= w_dy[3:1];
                            r_num    <= w_num[r_s];
                            r_xb     <= w_x[r_s][8:1];
                            r_cnt    <= '0;
                        end else if (!w_last) begin
                            r_s <= r_s - 1'b1;
                        end
                    end
                    DRAW: r_cnt <= r_cnt + 8'd1;
                    TAIL: if (!w_last) r_s <= r_s - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // A set caused by an overlapping line start beats a same-cycle clear.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n)
            r_overrun <= 1'b0;
        else if (i_Line_Start && (r_state != IDLE))
            r_overrun <= 1'b1;
        else if (w_attr_wr && (i_Cpu_Addr[1:0] == 2'd3))
            r_overrun <= 1'b0;
    end

    assign o_Overrun = r_overrun;

    logic w_unused;
    assign w_unused = ^{i_Cpu_Data[15:10], i_Cpu_Addr[11:2+SW], w_dy[0], w_x};
endmodule

// File: tb/tb_sprite_line_writer.sv
// Randomized bench for sprite_line_writer: a pixel-level line model computes
// each expected scanline from the sprite attribute table and the ROM contents.
module tb_sprite_line_writer;
    localparam int N = 8;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Line_Start = 1'b0;
    logic [9:0]  i_Next_Row = '0;
    logic        i_Bank = 1'b0;
    logic        i_Cpu_Write = 1'b0;
    logic [15:0] i_Cpu_Addr = '0;
    logic [15:0] i_Cpu_Data = '0;
    logic [5:0]  o_Rom_Sprite;
    logic [2:0]  o_Rom_Row;
    logic [2:0]  o_Rom_Col;
    logic [1:0]  rom_q = '0;
    logic        o_Lr_Write;
    logic [10:0] o_Lr_Addr;
    logic [1:0]  o_Lr_Data;
    logic        o_Busy;
    logic        o_Overrun;

    always #5 i_Clk = ~i_Clk;

    sprite_line_writer #(.NUM_SPRITES(N), .ATTR_PAGE(4'hE)) dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n), .i_Line_Start(i_Line_Start),
        .i_Next_Row(i_Next_Row), .i_Bank(i_Bank), .i_Cpu_Write(i_Cpu_Write),
        .i_Cpu_Addr(i_Cpu_Addr), .i_Cpu_Data(i_Cpu_Data),
        .o_Rom_Sprite(o_Rom_Sprite), .o_Rom_Row(o_Rom_Row), .o_Rom_Col(o_Rom_Col),
        .i_Rom_Pixel(rom_q), .o_Lr_Write(o_Lr_Write), .o_Lr_Addr(o_Lr_Addr),
        .o_Lr_Data(o_Lr_Data), .o_Busy(o_Busy), .o_Overrun(o_Overrun)
    );

    // Synchronous ROM: address seen in cycle c, pixel presented in cycle c+1.
    logic [1:0]  rom_tab [0:4095];
    logic [11:0] rom_a = '0;
    always @(negedge i_Clk) rom_a = {o_Rom_Sprite, o_Rom_Row, o_Rom_Col};
    always @(posedge i_Clk) rom_q <= rom_tab[rom_a];

    logic [1:0]  lram [0:2047];
    logic [10:0] wa_q[$];
    logic [1:0]  wd_q[$];
    logic [5:0]  rc_q[$];
    always @(negedge i_Clk) begin
        if (o_Lr_Write) begin
            lram[o_Lr_Addr] = o_Lr_Data;
            wa_q.push_back(o_Lr_Addr);
            wd_q.push_back(o_Lr_Data);
        end
        if (o_Rom_Sprite != 6'd0) rc_q.push_back({o_Rom_Row, o_Rom_Col});
    end

    int ax [N];
    int ay [N];
    int anum [N];
    bit aen [N];
    int exp_line [256];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void clear_model();
        for (int s = 0; s < N; s++) begin
            ax[s] = 0; ay[s] = 0; anum[s] = 0; aen[s] = 0;
        end
    endfunction

    function automatic void apply_wr(input logic [15:0] a, input logic [15:0] d);
        int s;
        if (a[15:12] != 4'hE) return;
        s = (int'(a) >> 2) % N;
        case (a[1:0])
            2'd0: ax[s] = int'(d[9:0]);
            2'd1: ay[s] = int'(d[9:0]);
            2'd2: begin anum[s] = int'(d[5:0]); aen[s] = d[8]; end
            default: ;
        endcase
    endfunction

    // Expected final line contents; returns the number of sprites that hit.
    function automatic int model_line(input logic [9:0] row);
        int hits = 0;
        for (int e = 0; e < 256; e++) exp_line[e] = 0;
        for (int s = N - 1; s >= 0; s--) begin
            int dy = (int'(row) - ay[s] + 1024) % 1024;
            if (aen[s] && dy < 16) begin
                hits++;
                for (int c = 0; c < 8; c++) begin
                    int e = (ax[s] % 512) / 2 + c;
                    int p = int'(rom_tab[anum[s] * 64 + (dy / 2) * 8 + c]);
                    if (e < 256 && p != 0) exp_line[e] = p;
                end
            end
        end
        return hits;
    endfunction

    task automatic do_reset();
        i_Line_Start = 0; i_Cpu_Write = 0;
        i_Reset_n = 0;
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Reset_n = 1;
        clear_model();
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
        @(posedge i_Clk); #1;
        i_Cpu_Write = 1; i_Cpu_Addr = a; i_Cpu_Data = d;
        @(posedge i_Clk); #1;
        i_Cpu_Write = 0;
        apply_wr(a, d);
    endtask

    task automatic set_sprite(input int s, input int x, input int y, input int num, input bit en);
        cpu_wr(16'(32'hE000 + s * 4 + 0), 16'(x));
        cpu_wr(16'(32'hE000 + s * 4 + 1), 16'(y));
        cpu_wr(16'(32'hE000 + s * 4 + 2), 16'(num + (en ? 256 : 0)));
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 3000) begin
            @(negedge i_Clk);
            if (!o_Busy) break;
            k++;
        end
        n_cmp++;
        if (o_Busy !== 1'b0) begin
            n_bad++; $display("FAIL %s_timeout: o_Busy=%0b still set, required 0", name, o_Busy);
        end
    endtask

    // Span counts the line-start cycle plus every busy cycle after it.
    task automatic run_line(input logic [9:0] row, input logic bank, input bit midw,
                            input logic [15:0] wa, input logic [15:0] wdat, output int span);
        wa_q.delete(); wd_q.delete(); rc_q.delete();
        @(posedge i_Clk); #1;
        i_Line_Start = 1; i_Next_Row = row; i_Bank = bank;
        @(posedge i_Clk); #1;
        i_Line_Start = 0;
        span = 1;
        while (span < 3000) begin
            @(negedge i_Clk);
            if (midw && span == 50) begin
                i_Cpu_Write = 1; i_Cpu_Addr = wa; i_Cpu_Data = wdat;
                apply_wr(wa, wdat);
            end else begin
                i_Cpu_Write = 0;
            end
            if (!o_Busy) break;
            span++;
        end
        i_Cpu_Write = 0;
        n_cmp++;
        if (o_Busy !== 1'b0) begin
            n_bad++; $display("FAIL line_timeout: o_Busy=%0b after %0d cycles, required 0", o_Busy, span);
        end
    endtask

    task automatic check_line(input string name, input logic bank, input int span, input int hits);
        int bad = 0;
        int fe = -1;
        for (int e = 0; e < 256; e++)
            if (int'(lram[int'(bank) * 256 + e]) != exp_line[e]) begin
                bad++;
                if (fe < 0) fe = e;
            end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s_line: %0d entries differ, first entry %0d got %0d required %0d",
                     name, bad, fe, lram[int'(bank) * 256 + fe], exp_line[fe]);
        end
        n_cmp++;
        if (span != 257 + N + 9 * hits) begin
            n_bad++; $display("FAIL %s_span: got %0d cycles, required %0d", name, span, 257 + N + 9 * hits);
        end
    endtask

    function automatic int nz_writes();
        int n = 0;
        foreach (wd_q[i]) if (wd_q[i] != 2'd0) n++;
        return n;
    endfunction

    task automatic test_reset();
        @(negedge i_Clk);
        n_cmp++;
        if ({o_Lr_Write, o_Busy, o_Overrun} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: wr/busy/ovr=%b required 000", {o_Lr_Write, o_Busy, o_Overrun});
        end
        n_cmp++;
        if ({o_Rom_Sprite, o_Rom_Row, o_Rom_Col} !== 12'd0) begin
            n_bad++; $display("FAIL reset_rom: got %h required 000", {o_Rom_Sprite, o_Rom_Row, o_Rom_Col});
        end
        n_cmp++;
        if ({o_Lr_Addr, o_Lr_Data} !== 13'd0) begin
            n_bad++; $display("FAIL reset_lr: got %h required 0000", {o_Lr_Addr, o_Lr_Data});
        end
        do_reset();
    endtask

    task automatic test_clear_only();
        int span, hits, bad = 0;
        for (int e = 256; e < 512; e++) lram[e] = 2'd3;
        run_line(10'd5, 1'b1, 0, '0, '0, span);
        hits = model_line(10'd5);
        n_cmp++;
        if (wa_q.size() != 256) begin
            n_bad++; $display("FAIL clear_count: got %0d writes, required 256", wa_q.size());
        end
        foreach (wa_q[i]) if (wa_q[i] != 11'(256 + i) || wd_q[i] != 2'd0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL clear_order: %0d writes off the 0x100..0x1FF/data 0 sequence, required 0", bad);
        end
        n_cmp++;
        if (span != 265) begin
            n_bad++; $display("FAIL clear_busy: got %0d cycles, required 265", span);
        end
        check_line("clear", 1'b1, span, hits);
    endtask

    task automatic test_single_sprite();
        int span, hits, bad = 0;
        for (int i = 0; i < 64; i++) rom_tab[3 * 64 + i] = 2'd1;
        set_sprite(0, 100, 0, 3, 1);
        run_line(10'd6, 1'b0, 0, '0, '0, span);
        hits = model_line(10'd6);
        for (int c = 0; c < 8; c++) if (lram[50 + c] != 2'd1) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL single_pixels: %0d of entries 50..57 not 1, required 0", bad);
        end
        n_cmp++;
        if (rc_q.size() != 8) begin
            n_bad++; $display("FAIL single_rom_cycles: got %0d ROM fetches, required 8", rc_q.size());
        end
        bad = 0;
        foreach (rc_q[i]) if (rc_q[i] != {3'd3, 3'(i)}) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL single_rom_addr: %0d fetches not row 3 / col step, required 0", bad);
        end
        check_line("single", 1'b0, span, hits);
    endtask

    task automatic test_miss();
        int span, hits;
        run_line(10'd16, 1'b0, 0, '0, '0, span);
        hits = model_line(10'd16);
        n_cmp++;
        if (nz_writes() != 0) begin
            n_bad++; $display("FAIL miss16_writes: got %0d sprite writes, required 0", nz_writes());
        end
        check_line("miss16", 1'b0, span, hits);
        run_line(10'd1023, 1'b0, 0, '0, '0, span);
        hits = model_line(10'd1023);
        n_cmp++;
        if (nz_writes() != 0) begin
            n_bad++; $display("FAIL miss1023_writes: got %0d sprite writes, required 0", nz_writes());
        end
        check_line("miss1023", 1'b0, span, hits);
    endtask

    task automatic test_priority();
        int span, hits, bad = 0;
        int want [8] = '{2, 2, 2, 2, 3, 2, 2, 2};
        for (int i = 0; i < 64; i++) begin
            rom_tab[5 * 64 + i] = (i % 8 == 4) ? 2'd0 : 2'd2;
            rom_tab[6 * 64 + i] = 2'd3;
        end
        set_sprite(1, 20, 0, 6, 1);
        set_sprite(0, 20, 0, 5, 1);
        run_line(10'd9, 1'b1, 0, '0, '0, span);
        hits = model_line(10'd9);
        for (int c = 0; c < 8; c++) if (int'(lram[256 + 10 + c]) != want[c]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL priority_pixels: %0d of entries 10..17 wrong, required 0", bad);
        end
        check_line("priority", 1'b1, span, hits);
    endtask

    task automatic test_clip();
        int span, hits, mn = 999;
        cpu_wr(16'hE006, 16'h0000);
        set_sprite(0, 500, 0, 3, 1);
        run_line(10'd2, 1'b0, 0, '0, '0, span);
        hits = model_line(10'd2);
        foreach (wd_q[i]) if (wd_q[i] != 2'd0 && int'(wa_q[i]) < mn) mn = int'(wa_q[i]);
        n_cmp++;
        if (nz_writes() != 6) begin
            n_bad++; $display("FAIL clip_count: got %0d sprite writes, required 6", nz_writes());
        end
        n_cmp++;
        if (mn != 250) begin
            n_bad++; $display("FAIL clip_lowest: lowest sprite write entry %0d, required 250", mn);
        end
        check_line("clip", 1'b0, span, hits);
    endtask

    task automatic test_overrun();
        int span, bad = 0;
        do_reset();
        @(posedge i_Clk); #1;
        i_Line_Start = 1; i_Next_Row = 10'd10; i_Bank = 1'b0;
        @(posedge i_Clk); #1;
        i_Line_Start = 0;
        repeat (100) @(posedge i_Clk);
        #1;
        i_Line_Start = 1; i_Next_Row = 10'd11; i_Bank = 1'b1;
        @(posedge i_Clk); #1;
        i_Line_Start = 0;
        wa_q.delete(); wd_q.delete();
        @(negedge i_Clk);
        n_cmp++;
        if (o_Overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set: got %0b, required 1", o_Overrun);
        end
        n_cmp++;
        if (o_Lr_Write !== 1'b1 || o_Lr_Addr !== 11'h100) begin
            n_bad++; $display("FAIL overrun_restart: wr=%0b addr=%h, required 1/100", o_Lr_Write, o_Lr_Addr);
        end
        wait_idle("overrun");
        foreach (wa_q[i]) if (wa_q[i][10:8] != 3'b001) bad++;
        n_cmp++;
        if (wa_q.size() != 256 || bad != 0) begin
            n_bad++; $display("FAIL overrun_clear: %0d writes, %0d outside bank 1, required 256/0", wa_q.size(), bad);
        end
        n_cmp++;
        if (o_Overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_sticky: got %0b, required 1", o_Overrun);
        end
        cpu_wr(16'hE003, 16'h0000);
        @(negedge i_Clk);
        n_cmp++;
        if (o_Overrun !== 1'b0) begin
            n_bad++; $display("FAIL overrun_clr: got %0b, required 0", o_Overrun);
        end
        run_line(10'd12, 1'b0, 0, '0, '0, span);
        n_cmp++;
        if (o_Overrun !== 1'b0) begin
            n_bad++; $display("FAIL overrun_idle_start: got %0b, required 0", o_Overrun);
        end
        @(posedge i_Clk); #1;
        i_Line_Start = 1;
        @(posedge i_Clk); #1;
        i_Line_Start = 0;
        repeat (10) @(posedge i_Clk);
        #1;
        i_Line_Start = 1; i_Cpu_Write = 1; i_Cpu_Addr = 16'hE00F; i_Cpu_Data = 16'h0;
        @(posedge i_Clk); #1;
        i_Line_Start = 0; i_Cpu_Write = 0;
        @(negedge i_Clk);
        n_cmp++;
        if (o_Overrun !== 1'b1) begin
            n_bad++; $display("FAIL overrun_set_wins: got %0b, required 1", o_Overrun);
        end
        wait_idle("overrun2");
        cpu_wr(16'hE003, 16'h0000);
    endtask

    task automatic test_random();
        int span, hits;
        logic [9:0] row;
        logic bank;
        logic [15:0] wa;
        for (int ln = 0; ln < 6; ln++) begin
            for (int i = 0; i < 4096; i++) rom_tab[i] = 2'($urandom_range(0, 3));
            row = 10'($urandom);
            bank = 1'($urandom);
            for (int s = 0; s < N; s++)
                set_sprite(s, $urandom_range(0, 1023), (int'(row) - $urandom_range(0, 20) + 1024) % 1024,
                           $urandom_range(0, 63), $urandom_range(0, 3) != 0);
            wa = 16'(($urandom_range(0, 1) != 0 ? 32'hE000 : 32'hD000)
                     + $urandom_range(0, N - 1) * 4 + $urandom_range(0, 2));
            run_line(row, bank, 1, wa, 16'($urandom), span);
            hits = model_line(row);
            check_line("random", bank, span, hits);
        end
    endtask

    task automatic test_reset_mid_draw();
        int k = 0;
        int span, hits;
        for (int i = 0; i < 64; i++) rom_tab[9 * 64 + i] = 2'd1;
        do_reset();
        set_sprite(2, 40, 100, 9, 1);
        @(posedge i_Clk); #1;
        i_Line_Start = 1; i_Next_Row = 10'd104; i_Bank = 1'b0;
        @(posedge i_Clk); #1;
        i_Line_Start = 0;
        while (k < 400) begin
            @(negedge i_Clk);
            if (o_Rom_Sprite == 6'd9) break;
            k++;
        end
        n_cmp++;
        if (o_Rom_Sprite !== 6'd9) begin
            n_bad++; $display("FAIL rstdraw_reach: sprite %0d never fetched, got %0d", 9, o_Rom_Sprite);
        end
        @(posedge i_Clk); #2;
        n_cmp++;
        if (o_Lr_Write !== 1'b1) begin
            n_bad++; $display("FAIL rstdraw_prewrite: got %0b, required 1", o_Lr_Write);
        end
        i_Reset_n = 0;
        #1;
        n_cmp++;
        if (o_Lr_Write !== 1'b0 || o_Busy !== 1'b0) begin
            n_bad++; $display("FAIL rstdraw_immediate: wr=%0b busy=%0b, required 0/0", o_Lr_Write, o_Busy);
        end
        wa_q.delete();
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        i_Reset_n = 1;
        clear_model();
        repeat (5) @(negedge i_Clk);
        n_cmp++;
        if (wa_q.size() != 0) begin
            n_bad++; $display("FAIL rstdraw_quiet: got %0d writes after reset, required 0", wa_q.size());
        end
        run_line(10'd104, 1'b0, 0, '0, '0, span);
        hits = model_line(10'd104);
        n_cmp++;
        if (nz_writes() != 0) begin
            n_bad++; $display("FAIL rstdraw_attrs: got %0d sprite writes, required 0", nz_writes());
        end
        check_line("rstdraw", 1'b0, span, hits);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_tab[i] = 2'd0;
        for (int i = 0; i < 2048; i++) lram[i] = 2'd0;
        clear_model();
        test_reset();
        test_clear_only();
        test_single_sprite();
        test_miss();
        test_priority();
        test_clip();
        test_overrun();
        test_random();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
